fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Walks a byte-addressed 8-bit PC, issues one read
// at a time to instruction memory and hands each returned word, tagged with
// its PC, to the IF/ID register. It handles decode back-pressure (stall) and
// redirects from the resolving stage (branch_taken / branch_target),
// including a redirect that arrives while a memory read is still in flight.
//
// Parameters
//   RESET_PC      PC loaded on reset and fetched first after reset release
//   PC_STEP       sequential PC increment in bytes
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   stall         decode cannot accept a new instruction
//   branch_taken  one-cycle redirect request
//   branch_target redirect PC, sampled with branch_taken
//   imem_req      memory read request (one outstanding at most)
//   imem_addr     memory read address, stable while imem_req=1
//   imem_ready    memory response strobe, data valid the same cycle
//   imem_rdata    memory read data
//   PC            PC of the presented instruction
//   instruction   presented instruction word
//   valid_PC      PC/instruction pair is valid this cycle
//   flush         one-cycle pulse telling IF/ID to load a bubble
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [7:0]  PC,
  output logic [31:0] instruction,
  output logic        valid_PC,
  output logic        flush
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] fetch_pc;
  // Redirect target remembered while the abandoned read is still in flight.
  logic [7:0] drain_tgt;

  // Sequential increment; 8-bit modulo, so FC + 4 wraps to 00 silently.
  function automatic logic [7:0] pc_inc(input logic [7:0] pc);
    pc_inc = pc + 8'(PC_STEP);
  endfunction

  // The read address is the fetch PC itself. In DRAIN the fetch PC is left
  // untouched, which keeps the address of the outstanding read stable.
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      drain_tgt   <= RESET_PC;
      PC          <= 8'h00;
      instruction <= 32'h0;
      valid_PC    <= 1'b0;
      flush       <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      // flush and valid_PC are single-cycle unless re-asserted below.
      flush    <= 1'b0;
      valid_PC <= 1'b0;

      case (state)
        // One quiet cycle after reset; any late response is ignored here.
        IDLE: begin
          fetch_pc <= RESET_PC;
          imem_req <= 1'b1;
          state    <= FETCH;
        end

        FETCH: begin
          if (branch_taken) begin
            flush <= 1'b1;
            if (imem_ready) begin
              // Response arrives with the redirect: drop it, refetch at target.
              fetch_pc <= branch_target;
            end else begin
              // Read still in flight: let it complete, then discard it.
              drain_tgt <= branch_target;
              state     <= DRAIN;
            end
          end else if (imem_ready) begin
            PC          <= fetch_pc;
            instruction <= imem_rdata;
            valid_PC    <= 1'b1;
            if (stall) begin
              // Keep presenting this word; fetch_pc advances on release.
              imem_req <= 1'b0;
              state    <= HOLD;
            end else begin
              fetch_pc <= pc_inc(fetch_pc);
            end
          end
        end

        // The held pair lives in PC/instruction; valid_PC keeps it presented.
        HOLD: begin
          if (branch_taken) begin
            flush    <= 1'b1;
            fetch_pc <= branch_target;
            imem_req <= 1'b1;
            state    <= FETCH;
          end else if (stall) begin
            valid_PC <= 1'b1;
          end else begin
            fetch_pc <= pc_inc(fetch_pc);
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end

        // Waiting out an abandoned read; its data is never presented.
        DRAIN: begin
          if (branch_taken) begin
            flush <= 1'b1;
            if (imem_ready) begin
              fetch_pc <= branch_target;
              state    <= FETCH;
            end else begin
              drain_tgt <= branch_target;
            end
          end else if (imem_ready) begin
            fetch_pc <= drain_tgt;
            state    <= FETCH;
          end
        end

        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [7:0] RESET_PC = 8'h00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [7:0]  PC;
  logic [31:0] instruction;
  logic        valid_PC;
  logic        flush;

  fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .PC(PC), .instruction(instruction), .valid_PC(valid_PC), .flush(flush)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [7:0] pc; logic [31:0] ins; } pair_t;
  typedef struct { bit r; bit s; bit b; logic [7:0] t; } stim_t;

  logic [31:0] mem [256];
  pair_t       exp_q[$];
  bit          flush_q[$];
  int          phase = 0;

  // Reference model: the address the next new read must use, and the state
  // of the read currently open on the memory port.
  logic [7:0]  next_pc = RESET_PC;
  logic [7:0]  req_addr = 8'h00;
  bit          req_open = 1'b0;
  bit          drop = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    next_pc  = RESET_PC;
    req_open = 1'b0;
    drop     = 1'b0;
    exp_q.delete();
    flush_q.delete();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_PC"}, 32'(PC), 32'h0);
    check({tag, "_instruction"}, instruction, 32'h0);
    check({tag, "_valid_PC"}, 32'(valid_PC), 32'h0);
    check({tag, "_flush"}, 32'(flush), 32'h0);
    check({tag, "_imem_req"}, 32'(imem_req), 32'h0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'(RESET_PC));
  endtask

  // Drive one cycle of memory/decode/branch stimulus and update the model.
  task automatic step(input bit rdy, input bit stl, input bit br, input logic [7:0] tgt);
    bit br_eff;
    @(negedge clk);
    // Redirects only come while something is in flight or presented.
    br_eff        = br && (imem_req || valid_PC);
    stall         = stl;
    imem_ready    = rdy;
    branch_taken  = br_eff;
    branch_target = tgt;
    imem_rdata    = rdy ? mem[imem_addr] : $urandom();
    if (imem_req) begin
      if (!req_open) begin
        check("fetch_addr", 32'(imem_addr), 32'(next_pc));
        req_open = 1'b1;
        req_addr = imem_addr;
        drop     = 1'b0;
      end else begin
        check("addr_stable", 32'(imem_addr), 32'(req_addr));
      end
    end
    if (br_eff) begin
      next_pc = tgt;
      if (imem_req) drop = 1'b1;
    end
    if (imem_req && rdy) begin
      if (!drop) begin
        exp_q.push_back('{pc: req_addr, ins: mem[req_addr]});
        next_pc = req_addr + 8'd4;
      end
      req_open = 1'b0;
    end
    flush_q.push_back(br_eff);
  endtask

  // Monitor: samples just after each rising edge and checks against the queues.
  initial begin : monitor
    bit          pv = 1'b0;
    logic [7:0]  ppc = 8'h00;
    logic [31:0] pins = 32'h0;
    int          cyc = 0;
    bit          seen_first = 1'b0;
    pair_t       e;
    bit          ef;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pv  = 1'b0;
        cyc = 0;
      end else begin
        cyc++;
        if (flush_q.size() > 0) begin
          ef = flush_q.pop_front();
          check("flush", 32'(flush), 32'(ef));
          if (ef) check("valid_after_branch", 32'(valid_PC), 32'h0);
        end
        if (valid_PC) begin
          // stall here is still the value of the cycle that just ended.
          if (!pv || !stall || PC != ppc) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_valid: PC %h presented, expected nothing (t=%0t)", PC, $time);
            end else begin
              e = exp_q.pop_front();
              check("PC", 32'(PC), 32'(e.pc));
              check("instruction", instruction, e.ins);
            end
            if (phase == 0 && !seen_first) begin
              check("first_valid_cycle", 32'(cyc), 32'd2);
              seen_first = 1'b1;
            end
          end else begin
            check("hold_instruction", instruction, pins);
          end
        end else if (phase == 0 && seen_first) begin
          check("zero_wait_valid", 32'(valid_PC), 32'h1);
        end
        pv   = valid_PC;
        ppc  = PC;
        pins = instruction;
      end
    end
  end

  initial begin : driver
    stim_t dir [16];
    dir = '{
      '{r:1, s:0, b:0, t:8'h00},   // 00
      '{r:1, s:0, b:0, t:8'h00},   // 04
      '{r:1, s:1, b:0, t:8'h00},   // 08 captured under stall
      '{r:0, s:1, b:0, t:8'h00},
      '{r:0, s:1, b:0, t:8'h00},
      '{r:0, s:0, b:0, t:8'h00},   // release, 0C next
      '{r:0, s:0, b:0, t:8'h00},   // 0C waiting
      '{r:0, s:0, b:1, t:8'h40},   // redirect while 0C in flight
      '{r:0, s:0, b:0, t:8'h00},
      '{r:1, s:0, b:0, t:8'h00},   // 0C data arrives, discarded
      '{r:1, s:1, b:1, t:8'h80},   // 40 data + stall + redirect
      '{r:1, s:0, b:0, t:8'h00},   // 80
      '{r:1, s:1, b:0, t:8'h00},   // 84 captured under stall
      '{r:0, s:0, b:1, t:8'h20},   // redirect out of the hold
      '{r:1, s:0, b:0, t:8'h00},   // 20
      '{r:1, s:0, b:0, t:8'h00}    // 24
    };
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    mem[8'h08] = 32'h2002_0005;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");

    // Zero-wait memory, no stall: long enough to wrap FC -> 00.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (70) step(1'b1, 1'b0, 1'b0, 8'h00);
    phase = 1;

    repeat (300) step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
                      $urandom_range(0, 15) == 0, 8'($urandom_range(0, 255)));

    // Park in DRAIN, then reset asynchronously mid-cycle.
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h55);
    @(negedge clk);
    imem_ready   = 1'b0;
    branch_taken = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("async_reset");
    model_reset();
    imem_ready = 1'b1;          // late response must be ignored
    imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) step(dir[i].r, dir[i].s, dir[i].b, dir[i].t);

    repeat (300) step($urandom_range(0, 9) < 5, $urandom_range(0, 9) < 4,
                      $urandom_range(0, 9) == 0, 8'($urandom_range(0, 255)));

    repeat (8) step(1'b1, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #2;
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
